// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package div_arbiter_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  // Requester index constants; grant[REQ1] / req[REQ1] belong to requester 1
  localparam logic REQ1 = 1'b0;
  localparam logic REQ2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin picker with a registered last-served pointer.
module rr_arb2
  import div_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       served,
  input  logic       served_idx,
  output logic       pick_valid_c,
  output logic       pick_idx_c
);

  logic last_q;
  logic last_d;

  // A lone request wins outright; a tie goes to the requester not served last
  always_comb begin
    pick_valid_c = |req;
    pick_idx_c   = REQ1;
    if (req[REQ1] && req[REQ2]) begin
      pick_idx_c = (last_q == REQ2) ? REQ1 : REQ2;
    end else if (req[REQ2]) begin
      pick_idx_c = REQ2;
    end
  end

  // Pointer follows whoever just completed
  always_comb begin
    last_d = last_q;
    if (served) begin
      last_d = served_idx;
    end
  end

  // Pointer register; reset favours requester 1 on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ2;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Sequences the shared restoring divider between two requesters.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DIV_WIDTH,
  parameter int unsigned TIMEOUT = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  output logic             done1,
  output logic             done2,
  output logic             err1,
  output logic             err2,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic             div_en,
  output logic             div_select,
  input  logic             div_busy,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_res,
  output logic [1:0]       grant
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               div_en_q, div_en_d;
  logic               div_select_q, div_select_d;
  logic [1:0]         grant_q, grant_d;
  logic               done1_q, done1_d, done2_q, done2_d;
  logic               err1_q, err1_d, err2_q, err2_d;
  logic [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;

  logic [1:0]         arb_req_c;
  logic               pick_valid_c;
  logic               pick_idx_c;
  logic               launch_c;
  logic               finish_c;
  logic               abort_c;
  logic               timeout_c;

  // In RELEASE the just-served requester is masked so a lingering req cannot relaunch it
  assign arb_req_c = (state_q == RELEASE) ? ({req2, req1} & ~grant_q) : {req2, req1};
  assign timeout_c = (wdog_q == CNT_W'(TIMEOUT - 1));

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (arb_req_c),
    .served       (finish_c),
    .served_idx   (owner_q),
    .pick_valid_c (pick_valid_c),
    .pick_idx_c   (pick_idx_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    div_en_d     = div_en_q;
    div_select_d = div_select_q;
    grant_d      = grant_q;
    done1_d      = 1'b0;
    done2_d      = 1'b0;
    err1_d       = 1'b0;
    err2_d       = 1'b0;
    res1_d       = res1_q;
    res2_d       = res2_q;
    wdog_d       = wdog_q;
    launch_c     = 1'b0;
    finish_c     = 1'b0;
    abort_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_en_d = 1'b0;
        grant_d  = 2'b00;
        wdog_d   = '0;
        launch_c = pick_valid_c;
      end
      LAUNCH: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (timeout_c) begin
          finish_c = 1'b1;
          abort_c  = 1'b1;
        end else if (div_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (div_ready) begin
          finish_c = 1'b1;
        end else if (timeout_c) begin
          finish_c = 1'b1;
          abort_c  = 1'b1;
        end
      end
      RELEASE: begin
        wdog_d   = '0;
        launch_c = pick_valid_c;
        if (!pick_valid_c) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch_c) begin
      state_d      = LAUNCH;
      owner_d      = pick_idx_c;
      div_en_d     = 1'b1;
      div_select_d = (pick_idx_c == REQ1);
      grant_d      = (pick_idx_c == REQ1) ? 2'b01 : 2'b10;
      wdog_d       = '0;
    end

    if (finish_c) begin
      state_d  = RELEASE;
      div_en_d = 1'b0;
      wdog_d   = '0;
      if (owner_q == REQ1) begin
        done1_d = 1'b1;
        err1_d  = abort_c;
        res1_d  = abort_c ? '0 : div_res;
      end else begin
        done2_d = 1'b1;
        err2_d  = abort_c;
        res2_d  = abort_c ? '0 : div_res;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ1;
      div_en_q     <= 1'b0;
      div_select_q <= 1'b1;
      grant_q      <= 2'b00;
      done1_q      <= 1'b0;
      done2_q      <= 1'b0;
      err1_q       <= 1'b0;
      err2_q       <= 1'b0;
      res1_q       <= '0;
      res2_q       <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      div_en_q     <= div_en_d;
      div_select_q <= div_select_d;
      grant_q      <= grant_d;
      done1_q      <= done1_d;
      done2_q      <= done2_d;
      err1_q       <= err1_d;
      err2_q       <= err2_d;
      res1_q       <= res1_d;
      res2_q       <= res2_d;
      wdog_q       <= wdog_d;
    end
  end

  assign done1      = done1_q;
  assign done2      = done2_q;
  assign err1       = err1_q;
  assign err2       = err2_q;
  assign res1       = res1_q;
  assign res2       = res2_q;
  assign div_en     = div_en_q;
  assign div_select = div_select_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider stub.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 96;

  logic         clk = 1'b0;
  logic         rst, req1, req2;
  logic         done1, done2, err1, err2;
  logic [W-1:0] res1, res2, div_res;
  logic         div_en, div_select, div_busy, div_ready;
  logic [1:0]   grant;
  logic [W-1:0] dvd1, dvs1, dvd2, dvs2;

  int total = 0;
  int bad   = 0;
  bit stall = 1'b0;
  int lat_cfg = 17;
  logic rdy_before;

  always #5 clk = ~clk;

  div_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2),
    .done1(done1), .done2(done2), .err1(err1), .err2(err2),
    .res1(res1), .res2(res2), .div_en(div_en), .div_select(div_select),
    .div_busy(div_busy), .div_ready(div_ready), .div_res(div_res), .grant(grant)
  );

  function automatic logic [W-1:0] quot(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '0 : a / b;
  endfunction

  // Divider stub: loads on en, busy for lat_cfg cycles, then ready until en drops
  int           m_cnt;
  logic         m_busy = 1'b0, m_ready = 1'b0;
  logic [W-1:0] m_res  = '0;
  always @(posedge clk) begin
    if (!div_en) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
    end else if (!m_busy && !m_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= lat_cfg;
      m_res  <= div_select ? quot(dvd1, dvs1) : quot(dvd2, dvs2);
    end else if (m_busy && !stall) begin
      if (m_cnt <= 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign div_busy  = m_busy;
  assign div_ready = m_ready;
  assign div_res   = m_ready ? m_res : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    rdy_before = div_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int which, input int max_cyc,
                           output bit seen, output int cyc, output logic rdy_at);
    seen   = 1'b0;
    cyc    = 0;
    rdy_at = 1'b0;
    while (!seen && cyc < max_cyc) begin
      step();
      cyc++;
      if ((which == 1 && done1) || (which == 2 && done2)) begin
        seen   = 1'b1;
        rdy_at = rdy_before;
      end
    end
  endtask

  typedef struct {
    int           who;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs[8];
  bit           seen;
  int           cyc, low, who, oth, last_done, ndone;
  logic         rdy_at;
  logic [W-1:0] other_before;
  bit           pend[3], hold[3];
  logic [W-1:0] ra[3], rb[3];

  initial begin
    vecs[0] = '{1, 16'd100,   16'd7,     16'd14};
    vecs[1] = '{2, 16'd5,     16'd0,     16'd0};
    vecs[2] = '{1, 16'hFFFF,  16'hFFFF,  16'd1};
    vecs[3] = '{2, 16'd12345, 16'd123,   16'd100};
    vecs[4] = '{1, 16'd0,     16'd9,     16'd0};
    vecs[5] = '{2, 16'hFFFF,  16'd2,     16'h7FFF};
    vecs[6] = '{1, 16'd7,     16'd0,     16'd0};
    vecs[7] = '{2, 16'd60000, 16'd3,     16'd20000};

    rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
    dvd1 = '0; dvs1 = '0; dvd2 = '0; dvs2 = '0;
    step(); step();
    chk("rst_div_en", div_en, 0);
    chk("rst_div_select", div_select, 1);
    chk("rst_grant", grant, 0);
    chk("rst_done", {done2, done1}, 0);
    chk("rst_err", {err2, err1}, 0);
    chk("rst_res1", res1, 0);
    chk("rst_res2", res2, 0);
    rst = 1'b0;
    step();

    // Tie straight after reset: requester 1 first, one idle cycle, then requester 2
    dvd1 = 16'd1000; dvs1 = 16'd10; dvd2 = 16'hFFFF; dvs2 = 16'd1;
    req1 = 1'b1; req2 = 1'b1;
    wait_done(1, 200, seen, cyc, rdy_at);
    chk("tie_done1_seen", seen, 1);
    chk("tie_done2_quiet", done2, 0);
    chk("tie_res1", res1, 16'd100);
    req1 = 1'b0;
    low = 0;
    while (!div_en && low < 10) begin
      low++;
      step();
    end
    chk("tie_en_low_cycles", low, 1);
    chk("tie_grant2", grant, 2'b10);
    wait_done(2, 200, seen, cyc, rdy_at);
    chk("tie_done2_seen", seen, 1);
    chk("tie_res2", res2, 16'hFFFF);
    req2 = 1'b0;
    step();

    // Both held for four jobs: order must alternate 1,2,1,2
    dvd1 = 16'd200; dvs1 = 16'd4; dvd2 = 16'd90; dvs2 = 16'd9;
    req1 = 1'b1; req2 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc = 0;
      while (!(done1 || done2) && cyc < 300) begin
        step();
        cyc++;
      end
      chk("alt_order", {done2, done1}, (j % 2 == 0) ? 2'b01 : 2'b10);
      if (j == 3) begin
        req1 = 1'b0;
        req2 = 1'b0;
      end
      if (j < 3) step();
    end
    chk("alt_res1", res1, 16'd50);
    chk("alt_res2", res2, 16'd10);
    step(); step();

    // Table of single-requester operations
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].who == 1) begin
        dvd1 = vecs[i].dvd; dvs1 = vecs[i].dvs; req1 = 1'b1; other_before = res2;
      end else begin
        dvd2 = vecs[i].dvd; dvs2 = vecs[i].dvs; req2 = 1'b1; other_before = res1;
      end
      step();
      chk("vec_launch_en", div_en, 1);
      chk("vec_grant", grant, (vecs[i].who == 1) ? 2'b01 : 2'b10);
      chk("vec_select", div_select, (vecs[i].who == 1) ? 1 : 0);
      wait_done(vecs[i].who, 200, seen, cyc, rdy_at);
      chk("vec_done_seen", seen, 1);
      chk("vec_ready_edge", rdy_at, 1);
      chk("vec_res", (vecs[i].who == 1) ? res1 : res2, vecs[i].exp);
      chk("vec_err", (vecs[i].who == 1) ? err1 : err2, 0);
      chk("vec_other_res", (vecs[i].who == 1) ? res2 : res1, other_before);
      req1 = 1'b0; req2 = 1'b0;
      step();
      chk("vec_release_en", div_en, 0);
      chk("vec_pulse_one_cycle", {done2, done1}, 0);
      step();
    end

    // Reset in the middle of RUN aborts silently
    dvd1 = 16'd100; dvs1 = 16'd7; req1 = 1'b1;
    cyc = 0;
    while (!div_busy && cyc < 20) begin
      step();
      cyc++;
    end
    chk("mid_busy_seen", div_busy, 1);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_en", div_en, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_res1", res1, 0);
    rst = 1'b0; req1 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done1 || done2) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    dvd1 = 16'd9; dvs1 = 16'd3; req1 = 1'b1;
    wait_done(1, 200, seen, cyc, rdy_at);
    chk("post_rst_seen", seen, 1);
    chk("post_rst_res1", res1, 16'd3);
    req1 = 1'b0;
    step(); step();

    // Stalled divider: watchdog fires after TIMEOUT cycles
    stall = 1'b1;
    dvd1 = 16'd1; dvs1 = 16'd1; req1 = 1'b1;
    step();
    chk("stall_launch_en", div_en, 1);
    wait_done(1, TMO + 20, seen, cyc, rdy_at);
    chk("stall_done_seen", seen, 1);
    chk("stall_latency", cyc, TMO);
    chk("stall_err1", err1, 1);
    chk("stall_res1", res1, 0);
    req1 = 1'b0;
    step();
    chk("stall_err_one_cycle", err1, 0);
    stall = 1'b0;
    step();
    dvd2 = 16'd50; dvs2 = 16'd5; req2 = 1'b1;
    wait_done(2, 200, seen, cyc, rdy_at);
    chk("after_stall_seen", seen, 1);
    chk("after_stall_res2", res2, 16'd10);
    chk("after_stall_err2", err2, 0);
    req2 = 1'b0;
    step(); step();

    // Randomized traffic against a request-level scoreboard
    last_done = 0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; hold[i] = 1'b0; ra[i] = '0; rb[i] = '0;
    end
    for (int c = 0; c < 4000; c++) begin
      lat_cfg = $urandom_range(1, 30);
      step();
      if (grant != 2'b00) chk("rand_sel_vs_grant", div_select, grant[0]);
      if (done1 || done2) begin
        chk("rand_one_done", done1 & done2, 0);
        who = done1 ? 1 : 2;
        oth = 3 - who;
        chk("rand_pending", pend[who], 1);
        chk("rand_res", (who == 1) ? res1 : res2, quot(ra[who], rb[who]));
        chk("rand_err", (who == 1) ? err1 : err2, 0);
        chk("rand_fair", (last_done == who) && hold[oth], 0);
        last_done = who;
        hold[oth] = pend[oth];
        hold[who] = 1'b0;
        pend[who] = 1'b0;
      end else if (c < 3600) begin
        for (int r = 1; r <= 2; r++) begin
          if (!pend[r] && $urandom_range(0, 3) == 0) begin
            pend[r] = 1'b1;
            ra[r]   = W'($urandom);
            rb[r]   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
          end
        end
      end
      dvd1 = ra[1]; dvs1 = rb[1]; dvd2 = ra[2]; dvs2 = rb[2];
      req1 = pend[1]; req2 = pend[2];
    end
    chk("rand_drain", {pend[2], pend[1]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares the team's single 16-bit restoring divider between two requesters: arbitrates round-robin, drives the divider's enable/select, tracks its Busy/Ready handshake, and returns a registered quotient with a one-cycle done pulse to the granted requester. Sits between requester logic and the divider. Operand buses run straight from requesters to the divider's Dividend1/Divisor1 (requester 1) and Dividend2/Divisor2 (requester 2) inputs; this block only sequences.

## Interface
- WIDTH, 16, quotient width; matches the divider.
- TIMEOUT, 96, max cycles in RUN before abort; must exceed the divider's worst-case latency.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req1, req2  in  1  level request; held high with stable operands until own done pulse.
- done1, done2  out  1  one-cycle pulse: result registered and valid.
- err1, err2  out  1  one-cycle pulse with doneN on timeout abort.
- res1, res2  out  WIDTH  per-requester quotient, held until overwritten.
- div_en  out  1  divider enable.
- div_select  out  1  1 = requester 1 operands, 0 = requester 2.
- div_busy, div_ready  in  1  divider status.
- div_res  in  WIDTH  divider quotient.
- grant  out  2  one-hot current owner, 00 when idle.

## Operation
- States: IDLE, LAUNCH, RUN, RELEASE.
- IDLE: div_en=0, grant=00. Any req high -> choose owner, latch div_select, -> LAUNCH.
- Arbitration: one request wins outright; both -> the one not served last. After reset the "last served" pointer = requester 2, so requester 1 wins first tie.
- LAUNCH: div_en=1. Hold until div_busy sampled 1 (operands loaded, divider's stale Ready cleared), then -> RUN. Tolerates the divider's extra post-completion en cycle.
- RUN: div_en=1. div_ready sampled 1 -> capture div_res into owner's resN, pulse doneN, update last-served pointer, -> RELEASE.
- RELEASE: div_en=0 exactly one cycle (divider returns to idle), then -> IDLE. Back-to-back requests re-arbitrate there.
- Watchdog: counts cycles in LAUNCH+RUN; reaching TIMEOUT -> resN=0, doneN and errN pulse together, -> RELEASE.
- Divide by zero: the divider returns 0 with Ready; forwarded as a normal result (errN stays 0).
- Owner dropping req mid-operation: the operation still completes and doneN still pulses. A grant is never revoked.
- div_select is constant from LAUNCH entry until RELEASE exits.

## Timing
- Reset values: div_en=0, div_select=1, grant=00, done1/2=0, err1/2=0, res1/2=0, state IDLE, watchdog 0, pointer=requester 2.
- rst mid-operation: next edge forces all reset values. The divider sees en=0 and drops Busy. No done pulse for the aborted job.
- req sampled in IDLE -> LAUNCH on next edge. div_en rises the same edge.
- RUN exit: resN and doneN update on the edge that samples div_ready=1. Pulse lasts exactly one cycle.
- Minimum gap between done pulses: divider latency + LAUNCH + RELEASE. div_en is low for at least 1 cycle between jobs.
- Requests arriving during LAUNCH/RUN/RELEASE wait; none are lost while held high.

## Structure
- Shared package: state enum (IDLE, LAUNCH, RUN, RELEASE), REQ1/REQ2 index constants, DIV_WIDTH=16.
- One sub-module: rr_arb2 (2-way round-robin picker with last-served pointer, combinational pick + registered pointer update on a "served" strobe).
- Watchdog counter width: $clog2(TIMEOUT+1).

## Test plan
- Single req1, 100/7 -> done1 pulse once, res1=14, grant=01 during op, div_select=1, res2 unchanged.
- req1 and req2 rise the same cycle (1000/10, 0xFFFF/1) -> requester 1 served first (res1=100), then requester 2 (res2=0xFFFF). div_en low exactly 1 cycle between jobs.
- Both held continuously for 4 jobs -> done pulses alternate 1,2,1,2. No starvation.
- req2 with divisor 0, dividend 5 -> res2=0, done2 pulse, err2=0.
- rst asserted mid-RUN -> next cycle div_en=0, grant=00, no done. A fresh req1 afterwards (9/3) completes with res1=3.
- Divider model stalled (div_ready never rises) -> done1 and err1 pulse together after TIMEOUT cycles with res1=0. Block then returns to IDLE and serves the next request.
